usb_app_regbridge: RTL and testbench

// - Application-side peer of the bulk endpoint FIFO interface: consumes host OUT bytes, sources IN bytes.
// - Parses host command frames and executes 8-bit register-bus reads/writes. Returns one response frame per command.
// - Sits between the USB CDC app_* streams and the local register file. Runs entirely in the app_clk_i domain.

---
 rtl/usb_regbridge_pkg.sv | 31 +++
 rtl/regbridge_timer.sv | 29 ++
 rtl/usb_app_regbridge.sv | 181 ++++++++++++++++++
 tb/tb_usb_app_regbridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_regbridge_pkg.sv
// Shared opcodes, status codes and FSM state encoding for the USB app register bridge.
package usb_regbridge_pkg;

  localparam logic [7:0] CMD_WR     = 8'h57;
  localparam logic [7:0] CMD_RD     = 8'h52;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_BAD_CMD = 8'hE1;
  localparam logic [7:0] ST_BAD_LEN = 8'hE2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_GET_ADDR = 4'd1,
    S_GET_LEN  = 4'd2,
    S_GET_DATA = 4'd3,
    S_RD_REQ   = 4'd4,
    S_RD_WAIT  = 4'd5,
    S_TX_HDR0  = 4'd6,
    S_TX_HDR1  = 4'd7,
    S_TX_DATA  = 4'd8
  } state_e;

  // States in which the bridge accepts host OUT bytes.
  function automatic logic is_rx_state(input logic [3:0] s);
    return (s == S_IDLE) || (s == S_GET_ADDR) || (s == S_GET_LEN) || (s == S_GET_DATA);
  endfunction

  function automatic logic is_tx_state(input logic [3:0] s);
    return (s == S_TX_HDR0) || (s == S_TX_HDR1) || (s == S_TX_DATA);
  endfunction

endpackage

// File: rtl/regbridge_timer.sv
// Loadable down-counter that flags expiry of the inter-byte frame timeout.
module regbridge_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic app_clk_i,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge app_clk_i or negedge rstn) begin
    if (!rstn) begin
      count_reg <= LOAD_VAL;
    end else if (load) begin
      count_reg <= LOAD_VAL;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expire = en && !load && (count_reg == '0);

endmodule

// File: rtl/usb_app_regbridge.sv
// Host command-frame parser driving an 8-bit register bus, one response frame per command.
// Optional inter-byte frame timeout is built when REGBRIDGE_TIMEOUT_EN is defined.
module usb_app_regbridge
  import usb_regbridge_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter int unsigned TIMEOUT_CYCLES = 48000
) (
  input  logic       app_clk_i,
  input  logic       rstn,
  input  logic [7:0] app_out_data_i,
  input  logic       app_out_valid_i,
  output logic       app_out_ready_o,
  output logic [7:0] app_in_data_o,
  output logic       app_in_valid_o,
  input  logic       app_in_ready_i,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_we_o,
  output logic       reg_re_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o,
  output logic [7:0] err_cnt_o
);

  localparam logic [3:0] IDLE     = S_IDLE;
  localparam logic [3:0] GET_ADDR = S_GET_ADDR;
  localparam logic [3:0] GET_LEN  = S_GET_LEN;
  localparam logic [3:0] GET_DATA = S_GET_DATA;
  localparam logic [3:0] RD_REQ   = S_RD_REQ;
  localparam logic [3:0] RD_WAIT  = S_RD_WAIT;
  localparam logic [3:0] TX_HDR0  = S_TX_HDR0;
  localparam logic [3:0] TX_HDR1  = S_TX_HDR1;
  localparam logic [3:0] TX_DATA  = S_TX_DATA;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [3:0] state_reg, state_next;
  logic [7:0] cmd_reg, addr_reg, len_reg, cnt_reg, status_reg;
  logic [7:0] in_data_reg, reg_addr_reg, reg_wdata_reg, err_cnt_reg;
  logic       in_valid_reg, out_ready_reg, we_reg, re_reg;

  logic out_acc, in_acc, cmd_known, len_bad, last_byte, timeout;

  assign out_acc   = app_out_valid_i && out_ready_reg;
  assign in_acc    = in_valid_reg && app_in_ready_i;
  assign cmd_known = (app_out_data_i == CMD_WR) || (app_out_data_i == CMD_RD);
  assign len_bad   = (app_out_data_i == 8'd0) || (app_out_data_i > MAX_LEN_B);
  assign last_byte = (8'(cnt_reg + 8'd1) == len_reg);

`ifdef REGBRIDGE_TIMEOUT_EN
  logic frame_rx;
  assign frame_rx = (state_reg == GET_ADDR) || (state_reg == GET_LEN) || (state_reg == GET_DATA);

  regbridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .app_clk_i(app_clk_i),
    .rstn     (rstn),
    .load     (out_acc || !frame_rx),
    .en       (frame_rx),
    .expire   (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (out_acc) state_next = cmd_known ? GET_ADDR : TX_HDR0;
      GET_ADDR: if (out_acc) state_next = GET_LEN;
      GET_LEN: begin
        if (out_acc) begin
          if (!len_bad && (cmd_reg == CMD_WR)) state_next = GET_DATA;
          else                                 state_next = TX_HDR0;
        end
      end
      GET_DATA: if (out_acc && last_byte) state_next = TX_HDR0;
      TX_HDR0:  if (in_acc) state_next = TX_HDR1;
      TX_HDR1: begin
        if (in_acc) begin
          if ((status_reg == ST_OK) && (cmd_reg == CMD_RD)) state_next = RD_REQ;
          else                                              state_next = IDLE;
        end
      end
      RD_REQ:   state_next = RD_WAIT;
      RD_WAIT:  state_next = TX_DATA;
      TX_DATA:  if (in_acc) state_next = last_byte ? IDLE : RD_REQ;
      default:  state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  always_ff @(posedge app_clk_i or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cmd_reg       <= '0;
      addr_reg      <= '0;
      len_reg       <= '0;
      cnt_reg       <= '0;
      status_reg    <= '0;
      in_data_reg   <= '0;
      in_valid_reg  <= 1'b0;
      out_ready_reg <= 1'b0;
      reg_addr_reg  <= '0;
      reg_wdata_reg <= '0;
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      in_valid_reg  <= is_tx_state(state_next);
      out_ready_reg <= is_rx_state(state_next);
      we_reg        <= 1'b0;
      re_reg        <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (out_acc) begin
            cmd_reg     <= app_out_data_i;
            cnt_reg     <= '0;
            status_reg  <= cmd_known ? ST_OK : ST_BAD_CMD;
            in_data_reg <= app_out_data_i;
          end
        end
        GET_ADDR: if (out_acc) addr_reg <= app_out_data_i;
        GET_LEN: begin
          if (out_acc) begin
            len_reg     <= app_out_data_i;
            status_reg  <= len_bad ? ST_BAD_LEN : ST_OK;
            in_data_reg <= cmd_reg;
          end
        end
        GET_DATA: begin
          if (out_acc) begin
            we_reg        <= 1'b1;
            reg_addr_reg  <= addr_reg;
            reg_wdata_reg <= app_out_data_i;
            addr_reg      <= addr_reg + 8'd1;
            cnt_reg       <= cnt_reg + 8'd1;
          end
        end
        TX_HDR0: if (in_acc) in_data_reg <= status_reg;
        TX_HDR1: begin
          if (in_acc) begin
            if ((status_reg != ST_OK) && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
            if (state_next == RD_REQ) begin
              re_reg       <= 1'b1;
              reg_addr_reg <= addr_reg;
            end
          end
        end
        RD_WAIT: in_data_reg <= reg_rdata_i;
        TX_DATA: begin
          // Next read is issued as this byte leaves, so reg_re_o lines up with RD_REQ.
          if (in_acc) begin
            addr_reg <= addr_reg + 8'd1;
            cnt_reg  <= cnt_reg + 8'd1;
            if (state_next == RD_REQ) begin
              re_reg       <= 1'b1;
              reg_addr_reg <= addr_reg + 8'd1;
            end
          end
        end
        default: ;
      endcase
      if (timeout && (err_cnt_reg != 8'hFF)) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign app_out_ready_o = out_ready_reg;
  assign app_in_data_o   = in_data_reg;
  assign app_in_valid_o  = in_valid_reg;
  assign reg_addr_o      = reg_addr_reg;
  assign reg_wdata_o     = reg_wdata_reg;
  assign reg_we_o        = we_reg;
  assign reg_re_o        = re_reg;
  assign busy_o          = (state_reg != IDLE);
  assign err_cnt_o       = err_cnt_reg;

endmodule

// File: tb/tb_usb_app_regbridge.sv
// Scoreboard bench for usb_app_regbridge: directed frames, backpressure, mid-frame reset, optional timeout.
module tb_usb_app_regbridge;

`ifdef REGBRIDGE_TIMEOUT_EN
  localparam int unsigned TB_TO = 20;
`else
  localparam int unsigned TB_TO = 48000;
`endif

  logic       app_clk_i = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] app_out_data_i = '0;
  logic       app_out_valid_i = 1'b0;
  logic       app_out_ready_o;
  logic [7:0] app_in_data_o;
  logic       app_in_valid_o;
  logic       app_in_ready_i = 1'b1;
  logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i, err_cnt_o;
  logic       reg_we_o, reg_re_o, busy_o;

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic bp_en = 1'b0;

  logic [7:0]  exp_in_q[$];
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];

  usb_app_regbridge #(.MAX_LEN(16), .TIMEOUT_CYCLES(TB_TO)) dut (
    .app_clk_i(app_clk_i), .rstn(rstn),
    .app_out_data_i(app_out_data_i), .app_out_valid_i(app_out_valid_i), .app_out_ready_o(app_out_ready_o),
    .app_in_data_o(app_in_data_o), .app_in_valid_o(app_in_valid_o), .app_in_ready_i(app_in_ready_i),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_we_o(reg_we_o), .reg_re_o(reg_re_o),
    .reg_rdata_i(reg_rdata_i), .busy_o(busy_o), .err_cnt_o(err_cnt_o)
  );

  always #5 app_clk_i = ~app_clk_i;

  // Register model: read data is addr ^ 0x5A, one cycle after the read strobe.
  always @(posedge app_clk_i) if (reg_re_o) reg_rdata_i <= reg_addr_o ^ 8'h5A;
  initial reg_rdata_i = '0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // IN-side ready, changed just after each rising edge.
  initial forever begin
    @(posedge app_clk_i);
    #1 app_in_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops expectations whenever the DUT presents something.
  logic       hold_flag = 1'b0;
  logic [7:0] hold_data = '0;
  initial forever begin
    @(negedge app_clk_i);
    if (!rstn) begin
      hold_flag = 1'b0;
    end else begin
      if (reg_we_o) begin
        if (exp_wr_q.size() == 0) chk("unexpected_we", {reg_addr_o, reg_wdata_o}, 16'hxxxx);
        else chk("reg_write", {reg_addr_o, reg_wdata_o}, exp_wr_q.pop_front());
      end
      if (reg_re_o) begin
        if (exp_rd_q.size() == 0) chk("unexpected_re", {8'h00, reg_addr_o}, 16'hxxxx);
        else chk("reg_read_addr", {8'h00, reg_addr_o}, {8'h00, exp_rd_q.pop_front()});
      end
      if (app_in_valid_o) begin
        if (hold_flag) chk("in_data_stable", {8'h00, app_in_data_o}, {8'h00, hold_data});
        if (app_out_ready_o) chk("out_ready_vs_in_valid", 16'h0001, 16'h0000);
        if (app_in_ready_i) begin
          hold_flag = 1'b0;
          if (exp_in_q.size() == 0) chk("unexpected_in", {8'h00, app_in_data_o}, 16'hxxxx);
          else chk("in_byte", {8'h00, app_in_data_o}, {8'h00, exp_in_q.pop_front()});
        end else begin
          hold_flag = 1'b1;
          hold_data = app_in_data_o;
        end
      end else begin
        hold_flag = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (bp_en) repeat ($urandom_range(0, 3)) @(negedge app_clk_i);
    @(negedge app_clk_i);
    app_out_valid_i = 1'b1;
    app_out_data_i  = b;
    n = 0;
    while (!app_out_ready_o && n < 500) begin
      @(negedge app_clk_i);
      n++;
    end
    if (n >= 500) begin
      chk_cnt++;
      $display("FAIL out_accept_timeout: byte %h not accepted within 500 cycles", b);
    end
    @(posedge app_clk_i);
    #1 app_out_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] f[$]);
    foreach (f[i]) send_byte(f[i]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge app_clk_i);
      n++;
    end while ((busy_o || exp_in_q.size() != 0 || exp_wr_q.size() != 0 || exp_rd_q.size() != 0) && n < 3000);
    if (n >= 3000) begin
      chk_cnt++;
      $display("FAIL drain_timeout: busy=%b in_q=%0d wr_q=%0d rd_q=%0d", busy_o,
               exp_in_q.size(), exp_wr_q.size(), exp_rd_q.size());
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_out_ready"}, {15'd0, app_out_ready_o}, 16'h0000);
    chk({tag, "_in_valid"},  {15'd0, app_in_valid_o}, 16'h0000);
    chk({tag, "_in_data"},   {8'd0, app_in_data_o}, 16'h0000);
    chk({tag, "_we_re"},     {14'd0, reg_we_o, reg_re_o}, 16'h0000);
    chk({tag, "_addr_wdata"}, {reg_addr_o, reg_wdata_o}, 16'h0000);
    chk({tag, "_busy"},      {15'd0, busy_o}, 16'h0000);
    chk({tag, "_err_cnt"},   {8'd0, err_cnt_o}, 16'h0000);
  endtask

  initial begin
    logic [7:0] fr[$];
    repeat (3) @(negedge app_clk_i);
    chk_outputs_zero("reset");
    rstn = 1'b1;
    repeat (2) @(negedge app_clk_i);
    chk("idle_out_ready", {15'd0, app_out_ready_o}, 16'h0001);

    // Write burst
    exp_wr_q = '{16'h10AA, 16'h11BB, 16'h12CC};
    exp_in_q = '{8'h57, 8'h00};
    fr = '{8'h57, 8'h10, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    send_frame(fr);
    wait_idle();
    chk("err_after_write", {8'd0, err_cnt_o}, 16'h0000);

    // Read burst wrapping FE -> FF -> 00
    exp_rd_q = '{8'hFE, 8'hFF, 8'h00};
    exp_in_q = '{8'h52, 8'h00, 8'hA4, 8'hA5, 8'h5A};
    fr = '{8'h52, 8'hFE, 8'h03};
    send_frame(fr);
    wait_idle();

    // Bad command
    exp_in_q = '{8'h33, 8'hE1};
    fr = '{8'h33};
    send_frame(fr);
    wait_idle();
    chk("err_after_bad_cmd", {8'd0, err_cnt_o}, 16'h0001);

    // LEN == 0
    exp_in_q = '{8'h57, 8'hE2};
    fr = '{8'h57, 8'h00, 8'h00};
    send_frame(fr);
    wait_idle();
    chk("err_after_len0", {8'd0, err_cnt_o}, 16'h0002);

    // LEN == MAX_LEN + 1
    exp_in_q = '{8'h52, 8'hE2};
    fr = '{8'h52, 8'h00, 8'h11};
    send_frame(fr);
    wait_idle();
    chk("err_after_len17", {8'd0, err_cnt_o}, 16'h0003);

    // Backpressure on both directions
    bp_en = 1'b1;
    exp_wr_q = '{16'h4001, 16'h4102, 16'h4203, 16'h4304};
    exp_in_q = '{8'h57, 8'h00};
    fr = '{8'h57, 8'h40, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(fr);
    wait_idle();
    exp_rd_q = '{8'h40, 8'h41, 8'h42, 8'h43};
    exp_in_q = '{8'h52, 8'h00, 8'h1A, 8'h1B, 8'h18, 8'h19};
    fr = '{8'h52, 8'h40, 8'h04};
    send_frame(fr);
    wait_idle();
    bp_en = 1'b0;
    chk("err_after_bp", {8'd0, err_cnt_o}, 16'h0003);

    // Reset in GET_DATA after one of three bytes
    exp_wr_q = '{16'h20AA};
    fr = '{8'h57, 8'h20, 8'h03, 8'hAA};
    send_frame(fr);
    repeat (2) @(negedge app_clk_i);
    chk("busy_mid_frame", {15'd0, busy_o}, 16'h0001);
    rstn = 1'b0;
    @(negedge app_clk_i);
    chk_outputs_zero("midreset");
    rstn = 1'b1;
    exp_rd_q = '{8'h00};
    exp_in_q = '{8'h52, 8'h00, 8'h5A};
    fr = '{8'h52, 8'h00, 8'h01};
    send_frame(fr);
    wait_idle();
    chk("err_after_reset_read", {8'd0, err_cnt_o}, 16'h0000);

`ifdef REGBRIDGE_TIMEOUT_EN
    fr = '{8'h57, 8'h10};
    send_frame(fr);
    repeat (10) @(negedge app_clk_i);
    chk("busy_before_timeout", {15'd0, busy_o}, 16'h0001);
    repeat (20) @(negedge app_clk_i);
    chk("busy_after_timeout", {15'd0, busy_o}, 16'h0000);
    chk("err_after_timeout", {8'd0, err_cnt_o}, 16'h0001);
    chk("ready_after_timeout", {15'd0, app_out_ready_o}, 16'h0001);
`endif

    repeat (5) @(negedge app_clk_i);
    chk("leftover_in", 16'(exp_in_q.size()), 16'h0000);
    chk("leftover_wr", 16'(exp_wr_q.size()), 16'h0000);
    chk("leftover_rd", 16'(exp_rd_q.size()), 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
